conv_window_ctrl: RTL

Streaming control path for the convolver datapath. It counts pixels accepted from the image stream into the line buffer and tracks each pixel's position in the frame. It raises `win_valid` when the K×K window in the line buffer is a legal output position, honouring stride and downstream backpressure. It also frames each image with a start/done handshake. It generalises the fixed per-row enable counter to parametrised image width/height, kernel size and stride, and adds input/output flow control and output coordinates.

---
 rtl/conv_window_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/conv_window_ctrl.sv
// Convolver window control: tracks pixel position in the frame and flags legal strided KxK windows.
// win_valid/out_row/out_col are registered one cycle after the completing pixel; input stalls while a window waits.
module conv_window_ctrl #(
  parameter int IMAGE_W     = 28,
  parameter int IMAGE_H     = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             win_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  output logic             busy,
  output logic             frame_done
);

  localparam int OUT_W = (IMAGE_W - KERNEL_SIZE) / STRIDE + 1;
  localparam int OUT_H = (IMAGE_H - KERNEL_SIZE) / STRIDE + 1;

  localparam logic [CNT_W-1:0] X_MAX  = CNT_W'(IMAGE_W - 1);
  localparam logic [CNT_W-1:0] Y_MAX  = CNT_W'(IMAGE_H - 1);
  localparam logic [CNT_W-1:0] K_M1   = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [CNT_W-1:0] S_M1   = CNT_W'(STRIDE - 1);
  localparam logic [CNT_W-1:0] OW_M1  = CNT_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0] OH_M1  = CNT_W'(OUT_H - 1);
  // Last input column/row that can still complete a strided window.
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(KERNEL_SIZE - 1 + (OUT_W - 1) * STRIDE);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(KERNEL_SIZE - 1 + (OUT_H - 1) * STRIDE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] x, y, px, py;
  logic [CNT_W-1:0] wcol, wrow;
  logic             last_taken;
  logic             take, final_take, win_set, last_pixel;

  always_comb begin
    take       = win_valid & out_ready;
    final_take = take && (out_row == OH_M1) && (out_col == OW_M1);
    last_pixel = shift_en && (x == X_MAX) && (y == Y_MAX);
    win_set    = shift_en && (x >= K_M1) && (y >= K_M1) && (x <= X_LAST) && (y <= Y_LAST)
                 && (px == '0) && (py == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_pixel) state_nxt = DRAIN;
      // The final window may already have gone if trailing pixels followed it.
      DRAIN:   if (final_take || last_taken) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    in_ready = (state == RUN) && !(win_valid && !out_ready);
    shift_en = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      px         <= '0;
      py         <= '0;
      wcol       <= '0;
      wrow       <= '0;
      out_row    <= '0;
      out_col    <= '0;
      win_valid  <= 1'b0;
      last_taken <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && (state_nxt == IDLE);
      if (state == IDLE && start) begin
        x          <= '0;
        y          <= '0;
        px         <= '0;
        py         <= '0;
        wcol       <= '0;
        wrow       <= '0;
        out_row    <= '0;
        out_col    <= '0;
        win_valid  <= 1'b0;
        last_taken <= 1'b0;
      end else begin
        if (shift_en) begin
          if (x == X_MAX) begin
            x  <= '0;
            px <= '0;
            if (y == Y_MAX) begin
              y  <= '0;
              py <= '0;
            end else begin
              y <= y + 1'b1;
              if (y >= K_M1) py <= (py == S_M1) ? '0 : py + 1'b1;
            end
          end else begin
            x <= x + 1'b1;
            if (x >= K_M1) px <= (px == S_M1) ? '0 : px + 1'b1;
          end
        end
        if (final_take) last_taken <= 1'b1;
        // A new window wins over clearing the one being taken this edge.
        if (win_set) begin
          win_valid <= 1'b1;
          out_row   <= wrow;
          out_col   <= wcol;
          if (wcol == OW_M1) begin
            wcol <= '0;
            wrow <= (wrow == OH_M1) ? '0 : wrow + 1'b1;
          end else begin
            wcol <= wcol + 1'b1;
          end
        end else if (take) begin
          win_valid <= 1'b0;
        end
      end
    end
  end

endmodule
